b2a_cgv14: RTL

B2A_CGV14 -- requirements
Module: b2a_cgv14

---
 rtl/b2a_cgv14.sv | 136 +++++++++++++
 1 files changed

// File: rtl/b2a_cgv14.sv
// Bit-serial Boolean-to-arithmetic masking converter: x = B0^B1 becomes A0 + A1 = x mod 2^k.
// Optional build macro B2A_CLEAR_EN wipes internal shares and randomness on FINISH -> IDLE.
module b2a_cgv14 #(
    parameter int k = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [k-1:0] B0_i,
    input  logic [k-1:0] B1_i,
    input  logic [k-1:0] R_i,
    input  logic [k-1:0] Rm_i,
    input  logic [k-2:0] Rxy_i,
    input  logic [k-2:0] Rxc_i,
    input  logic [k-2:0] Ryc_i,
    output logic         busy_o,
    output logic         finish_o,
    output logic [k-1:0] A0_o,
    output logic [k-1:0] A1_o
);
    localparam int CW = (k > 2) ? $clog2(k) : 1;
    localparam logic [CW-1:0] LAST = CW'(k - 2);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] INIT   = 3'd2;
    localparam logic [2:0] AND1   = 3'd3;
    localparam logic [2:0] AND2   = 3'd4;
    localparam logic [2:0] UNMASK = 3'd5;
    localparam logic [2:0] FINISH = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [k-1:0]  x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [k-1:0]  r_q, r_d, rm_q, rm_d, d0_q, d0_d, d1_q, d1_d;
    logic [k-1:0]  a0_q, a0_d, a1_q, a1_d;
    logic [k-2:0]  rxy_q, rxy_d, rxc_q, rxc_d, ryc_q, ryc_d;
    logic          c0_q, c0_d, c1_q, c1_d;
    // Per-AND cross terms, bit order {xy, xc, yc}.
    logic [2:0]    t00_q, t00_d, t01_q, t01_d, t10_q, t10_d, t11_q, t11_d;
    logic [2:0]    aa0, aa1, bb0, bb1, rr, z0, z1;

    assign aa0 = {x0_q[0], x0_q[0], y0_q[0]};
    assign aa1 = {x1_q[0], x1_q[0], y1_q[0]};
    assign bb0 = {y0_q[0], c0_q, c0_q};
    assign bb1 = {y1_q[0], c1_q, c1_q};
    assign rr  = {rxy_q[0], rxc_q[0], ryc_q[0]};
    assign z0  = t00_q ^ t01_q;
    assign z1  = t11_q ^ t10_q;

    always_comb begin
        state_d = state_q; cnt_d = cnt_q;
        x0_d = x0_q; x1_d = x1_q; y0_d = y0_q; y1_d = y1_q;
        r_d = r_q; rm_d = rm_q; d0_d = d0_q; d1_d = d1_q;
        a0_d = a0_q; a1_d = a1_q;
        rxy_d = rxy_q; rxc_d = rxc_q; ryc_d = ryc_q;
        c0_d = c0_q; c1_d = c1_q;
        t00_d = t00_q; t01_d = t01_q; t10_d = t10_q; t11_d = t11_q;
        case (state_q)
            IDLE: if (start_i) state_d = LOAD;
            LOAD: begin
                x0_d = B0_i; x1_d = B1_i; r_d = R_i; rm_d = Rm_i;
                rxy_d = Rxy_i; rxc_d = Rxc_i; ryc_d = Ryc_i;
                state_d = INIT;
            end
            INIT: begin
                y0_d = ~(r_q ^ rm_q);
                y1_d = rm_q;
                c0_d = 1'b1; c1_d = 1'b0;
                cnt_d = '0; d0_d = '0; d1_d = '0;
                state_d = AND1;
            end
            AND1: begin
                t00_d = aa0 & bb0;
                t01_d = (aa0 & bb1) ^ rr;
                t10_d = (aa1 & bb0) ^ rr;
                t11_d = aa1 & bb1;
                state_d = AND2;
            end
            AND2: begin
                // Sum bits enter at the MSB so D ends up LSB-aligned after k-1 rounds plus the top bit.
                d0_d = {x0_q[0] ^ y0_q[0] ^ c0_q, d0_q[k-1:1]};
                d1_d = {x1_q[0] ^ y1_q[0] ^ c1_q, d1_q[k-1:1]};
                c0_d = ^z0; c1_d = ^z1;
                x0_d = x0_q >> 1; x1_d = x1_q >> 1;
                y0_d = y0_q >> 1; y1_d = y1_q >> 1;
                rxy_d = rxy_q >> 1; rxc_d = rxc_q >> 1; ryc_d = ryc_q >> 1;
                cnt_d = cnt_q + CW'(1);
                state_d = (cnt_q == LAST) ? UNMASK : AND1;
            end
            UNMASK: begin
                a0_d = {x0_q[0] ^ y0_q[0] ^ c0_q ^ x1_q[0] ^ y1_q[0] ^ c1_q,
                        d0_q[k-1:1] ^ d1_q[k-1:1]};
                a1_d = r_q;
                state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
`ifdef B2A_CLEAR_EN
                cnt_d = '0;
                x0_d = '0; x1_d = '0; y0_d = '0; y1_d = '0;
                r_d = '0; rm_d = '0; d0_d = '0; d1_d = '0;
                rxy_d = '0; rxc_d = '0; ryc_d = '0;
                c0_d = 1'b0; c1_d = 1'b0;
                t00_d = '0; t01_d = '0; t10_d = '0; t11_d = '0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE; cnt_q <= '0;
            x0_q <= '0; x1_q <= '0; y0_q <= '0; y1_q <= '0;
            r_q <= '0; rm_q <= '0; d0_q <= '0; d1_q <= '0;
            a0_q <= '0; a1_q <= '0;
            rxy_q <= '0; rxc_q <= '0; ryc_q <= '0;
            c0_q <= 1'b0; c1_q <= 1'b0;
            t00_q <= '0; t01_q <= '0; t10_q <= '0; t11_q <= '0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d;
            x0_q <= x0_d; x1_q <= x1_d; y0_q <= y0_d; y1_q <= y1_d;
            r_q <= r_d; rm_q <= rm_d; d0_q <= d0_d; d1_q <= d1_d;
            a0_q <= a0_d; a1_q <= a1_d;
            rxy_q <= rxy_d; rxc_q <= rxc_d; ryc_q <= ryc_d;
            c0_q <= c0_d; c1_q <= c1_d;
            t00_q <= t00_d; t01_q <= t01_d; t10_q <= t10_d; t11_q <= t11_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign finish_o = (state_q == FINISH);
    assign A0_o     = a0_q;
    assign A1_o     = a1_q;
endmodule
